// File: rtl/aes_key_expander_if.sv
// Start/round-key handshake bundle for aes_key_expander.
// With AES_KEYEXP_LASTKEY_EN defined it also carries last_key/last_key_valid.
interface aes_key_expander_if #(
  parameter int KEY_LEN = 128
);
  logic               start;
  logic [KEY_LEN-1:0] key_in;
  logic               busy;
  logic               rk_valid;
  logic               rk_ready;
  logic [127:0]       rk_data;
  logic [3:0]         rk_round;
  logic               done;
`ifdef AES_KEYEXP_LASTKEY_EN
  logic [KEY_LEN-1:0] last_key;
  logic               last_key_valid;

  modport master (input start, key_in, rk_ready,
                  output busy, rk_valid, rk_data, rk_round, done, last_key, last_key_valid);
  modport slave  (output start, key_in, rk_ready,
                  input busy, rk_valid, rk_data, rk_round, done, last_key, last_key_valid);
`else
  modport master (input start, key_in, rk_ready,
                  output busy, rk_valid, rk_data, rk_round, done);
  modport slave  (output start, key_in, rk_ready,
                  input busy, rk_valid, rk_data, rk_round, done);
`endif
endinterface

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule: one word per clock from an Nk-word window, packed into round keys.
// Optional macro AES_KEYEXP_LASTKEY_EN adds last_key/last_key_valid for seeding the inverse schedule.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] b;
    p = '0;
    b = x;
    for (int k = 0; k < 8; k++) begin
      if (z[k]) p = p ^ b;
      b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;
  logic [7:0] sq;

  // Multiplicative inverse as a^254, then the affine transform
  always_comb begin
    inv = 8'h01;
    sq  = a;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_expander #(
  parameter int KEY_LEN = 128
) (
  input logic                clk,
  input logic                rst,
  aes_key_expander_if.master kif
);
  localparam int         NK     = KEY_LEN / 32;
  localparam int         NR     = NK + 6;
  localparam logic [5:0] LAST_I = 6'(4 * (NR + 1) - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [KEY_LEN-1:0] win_q, win_d;
  logic [5:0]         idx_q, idx_d;
  logic [2:0]         kmod_q, kmod_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [95:0]        asm_q, asm_d;
  logic               busy_q, busy_d;
  logic               rk_valid_q, rk_valid_d;
  logic [127:0]       rk_data_q, rk_data_d;
  logic [3:0]         rk_round_q, rk_round_d;
  logic               done_q, done_d;
`ifdef AES_KEYEXP_LASTKEY_EN
  logic [KEY_LEN-1:0] last_key_q, last_key_d;
  logic               last_key_valid_q, last_key_valid_d;
`endif

  logic [31:0] w_old, w_prev, sub_in, sub_out, t, word;
  logic        step;

  // Window holds w[i-Nk] in the MSB word and w[i-1] in the LSB word
  assign w_old  = win_q[KEY_LEN-1 -: 32];
  assign w_prev = win_q[31:0];
  assign sub_in = (kmod_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a(sub_in[8*g +: 8]), .y(sub_out[8*g +: 8]));
  end

  always_comb begin
    t = w_prev;
    if (kmod_q == 3'd0)                t = sub_out ^ {rcon_q, 24'h0};
    else if (NK == 8 && kmod_q == 3'd4) t = sub_out;
    // During the first Nk steps the window rotates the key words out unchanged
    word = (idx_q < 6'(NK)) ? w_old : (w_old ^ t);
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    idx_d      = idx_q;
    kmod_d     = kmod_q;
    rcon_d     = rcon_q;
    asm_d      = asm_q;
    busy_d     = busy_q;
    rk_valid_d = rk_valid_q;
    rk_data_d  = rk_data_q;
    rk_round_d = rk_round_q;
    done_d     = 1'b0;
    step       = 1'b0;
`ifdef AES_KEYEXP_LASTKEY_EN
    last_key_d       = last_key_q;
    last_key_valid_d = last_key_valid_q;
`endif
    if (rk_valid_q && kif.rk_ready) rk_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (kif.start && !done_q) begin
          state_d = S_RUN;
          win_d   = kif.key_in;
          idx_d   = '0;
          kmod_d  = '0;
          rcon_d  = 8'h01;
          busy_d  = 1'b1;
`ifdef AES_KEYEXP_LASTKEY_EN
          last_key_valid_d = 1'b0;
`endif
        end
      end
      S_RUN: begin
        step = !(rk_valid_q && !kif.rk_ready);
        if (step) begin
          win_d  = {win_q[KEY_LEN-33:0], word};
          idx_d  = idx_q + 6'd1;
          kmod_d = (kmod_q == 3'(NK - 1)) ? 3'd0 : kmod_q + 3'd1;
          if (kmod_q == 3'd0 && idx_q >= 6'(NK))
            rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
`ifdef AES_KEYEXP_LASTKEY_EN
          last_key_d = {last_key_q[KEY_LEN-33:0], word};
`endif
          case (idx_q[1:0])
            2'd0: asm_d[95:64] = word;
            2'd1: asm_d[63:32] = word;
            2'd2: asm_d[31:0]  = word;
            default: begin
              rk_valid_d = 1'b1;
              rk_data_d  = {asm_q, word};
              rk_round_d = idx_q[5:2];
            end
          endcase
          if (idx_q == LAST_I) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rk_valid_q && kif.rk_ready) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef AES_KEYEXP_LASTKEY_EN
          last_key_valid_d = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      win_q      <= '0;
      idx_q      <= '0;
      kmod_q     <= '0;
      rcon_q     <= '0;
      asm_q      <= '0;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_round_q <= '0;
      done_q     <= 1'b0;
`ifdef AES_KEYEXP_LASTKEY_EN
      last_key_q       <= '0;
      last_key_valid_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      idx_q      <= idx_d;
      kmod_q     <= kmod_d;
      rcon_q     <= rcon_d;
      asm_q      <= asm_d;
      busy_q     <= busy_d;
      rk_valid_q <= rk_valid_d;
      rk_data_q  <= rk_data_d;
      rk_round_q <= rk_round_d;
      done_q     <= done_d;
`ifdef AES_KEYEXP_LASTKEY_EN
      last_key_q       <= last_key_d;
      last_key_valid_q <= last_key_valid_d;
`endif
    end
  end

  assign kif.busy     = busy_q;
  assign kif.rk_valid = rk_valid_q;
  assign kif.rk_data  = rk_data_q;
  assign kif.rk_round = rk_round_q;
  assign kif.done     = done_q;
`ifdef AES_KEYEXP_LASTKEY_EN
  assign kif.last_key       = last_key_q;
  assign kif.last_key_valid = last_key_valid_q;
`endif
endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: one DUT per key length, checked against a FIPS-197 style key-schedule model.
module tb_aes_key_expander;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_key_expander_if #(.KEY_LEN(128)) if0 ();
  aes_key_expander_if #(.KEY_LEN(192)) if1 ();
  aes_key_expander_if #(.KEY_LEN(256)) if2 ();
  aes_key_expander #(.KEY_LEN(128)) dut0 (.clk(clk), .rst(rst), .kif(if0));
  aes_key_expander #(.KEY_LEN(192)) dut1 (.clk(clk), .rst(rst), .kif(if1));
  aes_key_expander #(.KEY_LEN(256)) dut2 (.clk(clk), .rst(rst), .kif(if2));

  logic [2:0]   start_v, ready_v, o_busy, o_valid, o_done;
  logic [255:0] key_v;
  logic [127:0] o_data [3];
  logic [3:0]   o_round [3];

  assign if0.start = start_v[0];  assign if1.start = start_v[1];  assign if2.start = start_v[2];
  assign if0.rk_ready = ready_v[0]; assign if1.rk_ready = ready_v[1]; assign if2.rk_ready = ready_v[2];
  assign if0.key_in = key_v[255:128];
  assign if1.key_in = key_v[255:64];
  assign if2.key_in = key_v;
  assign o_busy  = {if2.busy, if1.busy, if0.busy};
  assign o_valid = {if2.rk_valid, if1.rk_valid, if0.rk_valid};
  assign o_done  = {if2.done, if1.done, if0.done};
  assign o_data[0] = if0.rk_data;   assign o_data[1] = if1.rk_data;   assign o_data[2] = if2.rk_data;
  assign o_round[0] = if0.rk_round; assign o_round[1] = if1.rk_round; assign o_round[2] = if2.rk_round;
`ifdef AES_KEYEXP_LASTKEY_EN
  logic [255:0] o_lk [3];
  logic [2:0]   o_lkv;
  assign o_lk[0] = {if0.last_key, 128'h0};
  assign o_lk[1] = {if1.last_key, 64'h0};
  assign o_lk[2] = if2.last_key;
  assign o_lkv   = {if2.last_key_valid, if1.last_key_valid, if0.last_key_valid};
`endif

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0]  ref_w [60];
  logic [127:0] got_rk [15];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = SBOX[2047 - 8*int'(x[8*b +: 8]) -: 8];
    return r;
  endfunction

  task automatic build_ref(input int nk, input logic [255:0] key);
    logic [31:0] tmp;
    logic [7:0]  rc [10];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) ref_w[i] = key[255 - 32*i -: 32];
      else begin
        tmp = ref_w[i-1];
        if (i % nk == 0)               tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc[i/nk - 1], 24'h0};
        else if (nk > 6 && i % nk == 4) tmp = sub_word(tmp);
        ref_w[i] = ref_w[i-nk] ^ tmp;
      end
    end
  endtask

  function automatic logic [127:0] ref_rk(input int r);
    return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
  endfunction

  task automatic run(input int sel, input logic [255:0] key, input int ready_pct,
                     input bit poke, input int abort_at);
    int nk, nr, e, n_got, first_valid, budget, bad;
    bit fin, prev_stall;
    logic [127:0] prev_data;
    logic [3:0]   prev_round;
    logic [255:0] lk;
    nk = (sel == 0) ? 4 : (sel == 1) ? 6 : 8;
    nr = nk + 6;
    build_ref(nk, key);
    @(negedge clk);
    key_v = key;
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    chk("busy_after_start", 256'(o_busy[sel]), 256'(1));
    e = 0; n_got = 0; first_valid = -1; fin = 0; prev_stall = 0;
    prev_data = '0; prev_round = '0; lk = '0;
    budget = 4 * (nr + 1) * 12 + 40;
    while (!fin && e < budget) begin
      if (abort_at > 0 && e == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs_zero", {o_busy[sel], o_valid[sel], o_done[sel], o_round[sel], o_data[sel]}, '0);
        rst = 1'b0;
        bad = 0;
        repeat (8) begin @(negedge clk); if (o_valid[sel] || o_busy[sel]) bad++; end
        chk("no_valid_after_abort", 256'(bad), 256'(0));
        return;
      end
      ready_v[sel] = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
      start_v[sel] = poke && (e == 10);
      if (poke && e == 10) key_v = ~key;
      if (o_valid[sel] && ready_v[sel]) begin
        if (n_got <= nr) begin
          chk($sformatf("rk_data_k%0d_r%0d", nk, n_got), 256'(o_data[sel]), 256'(ref_rk(n_got)));
          chk($sformatf("rk_round_k%0d_r%0d", nk, n_got), 256'(o_round[sel]), 256'(n_got));
          got_rk[n_got] = o_data[sel];
        end else chk("extra_round_key", 256'(n_got), 256'(nr));
        n_got++;
      end
      prev_stall = o_valid[sel] && !ready_v[sel];
      prev_data  = o_data[sel];
      prev_round = o_round[sel];
      @(negedge clk);
      e++;
      if (prev_stall)
        chk("stall_stable", {o_valid[sel], o_round[sel], o_data[sel]}, {1'b1, prev_round, prev_data});
      if (o_valid[sel] && first_valid < 0) first_valid = e;
      if (o_done[sel]) begin
        fin = 1;
        chk("keys_received", 256'(n_got), 256'(nr + 1));
        chk("busy_at_done", 256'(o_busy[sel]), 256'(0));
        chk("valid_at_done", 256'(o_valid[sel]), 256'(0));
        if (ready_pct >= 100) begin
          chk("done_edge", 256'(e), 256'(4 * (nr + 1) + 1));
          chk("first_valid_edge", 256'(first_valid), 256'(4));
        end
`ifdef AES_KEYEXP_LASTKEY_EN
        for (int j = 0; j < nk; j++) lk[255 - 32*j -: 32] = ref_w[4*(nr+1) - nk + j];
        chk("last_key", o_lk[sel], lk);
        chk("last_key_valid", 256'(o_lkv[sel]), 256'(1));
`endif
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        chk("start_in_done_ignored", 256'(o_busy[sel]), 256'(0));
        chk("done_one_cycle", 256'(o_done[sel]), 256'(0));
      end
    end
    start_v[sel] = 1'b0;
    chk("done_seen", 256'(fin), 256'(1));
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    return k;
  endfunction

  initial begin
    start_v = '0;
    ready_v = '0;
    key_v   = '0;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++)
      chk($sformatf("reset_outputs_%0d", s),
          {o_busy[s], o_valid[s], o_done[s], o_round[s], o_data[s]}, '0);
    rst = 1'b0;

    run(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 100, 1, 0);
    chk("kat128_r0", 256'(got_rk[0]), 256'(128'h2b7e151628aed2a6abf7158809cf4f3c));
    chk("kat128_r1", 256'(got_rk[1]), 256'(128'ha0fafe1788542cb123a339392a6c7605));
    chk("kat128_r10", 256'(got_rk[10]), 256'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    run(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 100, 0, 0);
    chk("kat192_r12", 256'(got_rk[12]), 256'(128'he98ba06f448c773c8ecc720401002202));
    run(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 100, 0, 0);
    chk("kat256_r14", 256'(got_rk[14]), 256'(128'hfe4890d1e6188d0b046df344706c631e));

    run(0, rand_key(), 30, 0, 0);
    run(0, rand_key(), 30, 0, 0);
    run(0, rand_key(), 100, 0, 20);
    run(0, rand_key(), 100, 0, 0);
    run(1, rand_key(), 50, 0, 0);
    run(2, rand_key(), 50, 0, 0);
    run(2, rand_key(), 100, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
